// File: rtl/seg_pkg.sv
// ============================================================================
// seg_pkg : shared types and constants for the seven-segment display block
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         NDIG      = 8;

  typedef struct packed {
    logic [3:0] data;
    logic       dp;
    logic       written;
  } digit_t;

  // Active-low {a,b,c,d,e,f,g,dp} with dp off; entry 15 first
  localparam logic [15:0][7:0] HEX_TABLE = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

endpackage

`default_nettype wire

// File: rtl/seg_hex_dec.sv
// ============================================================================
// seg_hex_dec : hex nibble plus decimal point to active-low segment pattern
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] data,
  input  logic       dp,
  output logic [7:0] pattern
);

  logic [7:0] table_entry;

  assign table_entry = HEX_TABLE[data];
  assign pattern     = {table_entry[7:1], ~dp};

endmodule

`default_nettype wire

// File: rtl/seg_disp_ctrl.sv
// ============================================================================
// seg_disp_ctrl : two-requester round-robin digit store with blank/blink masks
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_all,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_idx,
  input  logic [3:0] req0_data,
  input  logic       req0_dp,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_idx,
  input  logic [3:0] req1_data,
  input  logic       req1_dp,
  input  logic [7:0] blank_mask,
  input  logic [7:0] blink_mask,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic [7:0] seg4,
  output logic [7:0] seg5,
  output logic [7:0] seg6,
  output logic [7:0] seg7
);

  localparam int CNT_W = $clog2(BLINK_DIV);

  digit_t           digits    [NDIG];
  logic [7:0]       hex_pat   [NDIG];
  logic [7:0]       seg_q     [NDIG];
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             rr_ptr;

  logic       grant0;
  logic       grant1;
  logic [2:0] wr_idx;
  logic [3:0] wr_data;
  logic       wr_dp;

  // rr_ptr = 0 favours requester 0 when both are valid
  assign grant0 = !rst && !clr_all && req0_valid && (!req1_valid || !rr_ptr);
  assign grant1 = !rst && !clr_all && req1_valid && (!req0_valid ||  rr_ptr);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    wr_idx  = req0_idx;
    wr_data = req0_data;
    wr_dp   = req0_dp;
    if (grant1) begin
      wr_idx  = req1_idx;
      wr_data = req1_data;
      wr_dp   = req1_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant0 || grant1) begin
      rr_ptr <= grant0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // clr_all forces both grants low, so it never coincides with a write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) begin
        digits[i] <= '0;
      end
    end else if (clr_all) begin
      for (int i = 0; i < NDIG; i++) begin
        digits[i].written <= 1'b0;
      end
    end else if (grant0 || grant1) begin
      digits[wr_idx] <= '{data: wr_data, dp: wr_dp, written: 1'b1};
    end
  end

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    seg_hex_dec u_dec (
      .data    (digits[gi].data),
      .dp      (digits[gi].dp),
      .pattern (hex_pat[gi])
    );
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NDIG; i++) begin
      if (rst) begin
        seg_q[i] <= SEG_BLANK;
      end else if (!digits[i].written || blank_mask[i]) begin
        seg_q[i] <= SEG_BLANK;
      end else if (blink_mask[i] && blink_phase) begin
        seg_q[i] <= SEG_BLANK;
      end else begin
        seg_q[i] <= hex_pat[i];
      end
    end
  end

  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign seg6 = seg_q[6];
  assign seg7 = seg_q[7];

endmodule

`default_nettype wire

// File: tb/tb_seg_disp_ctrl.sv
// ============================================================================
// tb_seg_disp_ctrl : table vectors, corner sequences and random traffic
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_disp_ctrl;

  localparam int BDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_all = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_idx = '0, req1_idx = '0;
  logic [3:0] req0_data = '0, req1_data = '0;
  logic       req0_dp = 1'b0, req1_dp = 1'b0;
  logic [7:0] blank_mask = '0, blink_mask = '0;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  seg_disp_ctrl #(.BLINK_DIV(BDIV)) dut (
    .clk(clk), .rst(rst), .clr_all(clr_all),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_idx(req0_idx),
    .req0_data(req0_data), .req0_dp(req0_dp),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_idx(req1_idx),
    .req1_data(req1_data), .req1_dp(req1_dp),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v0;
    logic [2:0] i0;
    logic [3:0] d0;
    bit         p0;
    bit         v1;
    logic [2:0] i1;
    logic [3:0] d1;
    bit         p1;
    bit         clr;
    logic [7:0] bm;
    logic [7:0] km;
  } stim_t;

  typedef struct {
    stim_t      s;
    bit         er0;
    bit         er1;
    int         cd;
    logic [7:0] cv;
  } vec_t;

  // Segment table written straight from the digit glyph list (dp off)
  localparam logic [7:0] HEX [16] = '{
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
    8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
    8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
    8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
  };

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: what each digit holds, which requester was served last,
  // and how many clock edges have elapsed since reset
  logic [3:0] m_data [8];
  logic       m_dp   [8];
  bit         m_wr   [8];
  logic [7:0] m_seg  [8];
  int         m_last = 1;
  int         m_ticks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_bank();
    return {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};
  endfunction

  function automatic logic [63:0] model_bank();
    logic [63:0] b;
    for (int i = 0; i < 8; i++) b[i*8 +: 8] = m_seg[i];
    return b;
  endfunction

  function automatic logic [7:0] dut_seg(input int i);
    logic [63:0] b;
    b = dut_bank();
    return b[i*8 +: 8];
  endfunction

  function automatic stim_t S(bit v0, int i0, int d0, bit p0, bit v1, int i1, int d1,
                              bit p1, bit clr, int bm);
    stim_t t;
    t.v0 = v0; t.i0 = 3'(i0); t.d0 = 4'(d0); t.p0 = p0;
    t.v1 = v1; t.i1 = 3'(i1); t.d1 = 4'(d1); t.p1 = p1;
    t.clr = clr; t.bm = 8'(bm); t.km = 8'h00;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_data[i] = '0; m_dp[i] = 1'b0; m_wr[i] = 1'b0; m_seg[i] = 8'hFF;
    end
    m_last  = 1;
    m_ticks = 0;
  endtask

  task automatic step(input stim_t s, output bit r0, output bit r1);
    bit         g0, g1, ph;
    logic [7:0] nxt [8];
    logic [7:0] pat;
    @(negedge clk);
    req0_valid = s.v0; req0_idx = s.i0; req0_data = s.d0; req0_dp = s.p0;
    req1_valid = s.v1; req1_idx = s.i1; req1_data = s.d1; req1_dp = s.p1;
    clr_all = s.clr; blank_mask = s.bm; blink_mask = s.km;
    #1;
    g0 = !rst && !s.clr && s.v0 && (!s.v1 || m_last == 1);
    g1 = !rst && !s.clr && s.v1 && (!s.v0 || m_last == 0);
    r0 = req0_ready;
    r1 = req1_ready;
    check("req0_ready", 64'(r0), 64'(g0));
    check("req1_ready", 64'(r1), 64'(g1));
    ph = ((m_ticks / BDIV) % 2) == 1;
    for (int i = 0; i < 8; i++) begin
      pat    = HEX[m_data[i]];
      pat[0] = ~m_dp[i];
      nxt[i] = (!m_wr[i] || s.bm[i] || (s.km[i] && ph)) ? 8'hFF : pat;
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_ticks++;
      if (s.clr) for (int i = 0; i < 8; i++) m_wr[i] = 1'b0;
      if (g0) begin m_data[s.i0] = s.d0; m_dp[s.i0] = s.p0; m_wr[s.i0] = 1'b1; m_last = 0; end
      if (g1) begin m_data[s.i1] = s.d1; m_dp[s.i1] = s.p1; m_wr[s.i1] = 1'b1; m_last = 1; end
      for (int i = 0; i < 8; i++) m_seg[i] = nxt[i];
    end
    #1;
    check("seg_bank", dut_bank(), model_bank());
  endtask

  vec_t       vecs [19];
  stim_t      idle;
  stim_t      s;
  bit         r0, r1;
  logic [7:0] samp [24];

  initial begin
    idle = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset with a request already presented: it must not be accepted
    rst = 1'b1;
    s = S(1, 3, 7, 0, 1, 4, 8, 0, 0, 0);
    for (int k = 0; k < 2; k++) step(s, r0, r1);
    check("ready_in_reset", {62'b0, r0, r1}, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step(idle, r0, r1);
    check("reset_blank", dut_bank(), {8{8'hFF}});

    vecs[0]  = '{S(1, 2, 5, 1, 0, 0, 0, 0, 0, 0),    1, 0,  2, 8'hFF};
    vecs[1]  = '{S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),    0, 0,  2, 8'b01001000};
    vecs[2]  = '{S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),    0, 0,  0, 8'hFF};
    vecs[3]  = '{S(1, 0, 12, 0, 1, 1, 13, 0, 0, 0),  0, 1, -1, 8'h00};
    vecs[4]  = '{S(1, 0, 12, 0, 1, 3, 14, 0, 0, 0),  1, 0, -1, 8'h00};
    vecs[5]  = '{S(1, 4, 10, 0, 1, 3, 14, 0, 0, 0),  0, 1, -1, 8'h00};
    vecs[6]  = '{S(1, 4, 10, 0, 1, 5, 15, 0, 0, 0),  1, 0,  0, 8'b01100011};
    vecs[7]  = '{S(0, 0, 0, 0, 1, 6, 6, 0, 0, 0),    0, 1, -1, 8'h00};
    vecs[8]  = '{S(1, 7, 3, 0, 1, 7, 9, 0, 0, 0),    1, 0, -1, 8'h00};
    vecs[9]  = '{S(0, 0, 0, 0, 1, 7, 9, 0, 0, 0),    0, 1,  7, 8'b00001101};
    vecs[10] = '{S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),    0, 0,  7, 8'b00001001};
    vecs[11] = '{S(1, 4, 10, 0, 0, 0, 0, 0, 0, 0),   1, 0, -1, 8'h00};
    vecs[12] = '{S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),    0, 0,  4, 8'b00010001};
    vecs[13] = '{S(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h10), 0, 0, 4, 8'hFF};
    vecs[14] = '{S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),    0, 0,  4, 8'b00010001};
    vecs[15] = '{S(0, 0, 0, 0, 1, 1, 2, 0, 1, 0),    0, 0, -1, 8'h00};
    vecs[16] = '{S(0, 0, 0, 0, 1, 1, 2, 0, 0, 0),    0, 1,  0, 8'hFF};
    vecs[17] = '{S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),    0, 0,  1, 8'b00100101};
    vecs[18] = '{S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),    0, 0,  2, 8'hFF};

    for (int k = 0; k < 19; k++) begin
      step(vecs[k].s, r0, r1);
      check($sformatf("vec%0d_ready", k), {62'b0, r0, r1}, {62'b0, vecs[k].er0, vecs[k].er1});
      if (vecs[k].cd >= 0)
        check($sformatf("vec%0d_seg%0d", k, vecs[k].cd), 64'(dut_seg(vecs[k].cd)), 64'(vecs[k].cv));
    end

    // Blink: seg0 shows '1' then dark, each for BDIV cycles
    step(S(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), r0, r1);
    step(idle, r0, r1);
    begin
      bit ok;
      int last, nchg;
      s = idle;
      s.km = 8'h01;
      for (int k = 0; k < 24; k++) begin
        step(s, r0, r1);
        samp[k] = seg0;
      end
      ok = 1'b1; last = -1; nchg = 0;
      for (int k = 0; k < 24; k++)
        if (samp[k] !== 8'b10011111 && samp[k] !== 8'hFF) ok = 1'b0;
      for (int k = 1; k < 24; k++) begin
        if (samp[k] !== samp[k-1]) begin
          if (last >= 0 && (k - last) != BDIV) ok = 1'b0;
          last = k;
          nchg++;
        end
      end
      if (nchg < 4) ok = 1'b0;
      check("blink_period", 64'(ok), 64'd1);
    end

    // Random traffic; a requester keeps its request stable until accepted
    begin
      bit h0, h1;
      h0 = 1'b0; h1 = 1'b0;
      s = idle;
      for (int k = 0; k < 400; k++) begin
        if (!h0) begin
          s.v0 = 1'($urandom_range(0, 1)); s.i0 = 3'($urandom);
          s.d0 = 4'($urandom); s.p0 = 1'($urandom);
        end
        if (!h1) begin
          s.v1 = 1'($urandom_range(0, 1)); s.i1 = 3'($urandom);
          s.d1 = 4'($urandom); s.p1 = 1'($urandom);
        end
        s.clr = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 7) == 0) s.bm = 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 7) == 0) s.km = 8'($urandom);
        step(s, r0, r1);
        h0 = s.v0 && !r0;
        h1 = s.v1 && !r1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
